// File: rtl/dino_motion_ctrl.sv
// Dino runner motion controller: per-frame height/velocity integration, jump/duck/death FSM, sprite select.
// Dino_Y is combinational from GroundY and the registered height; every other output is registered or decoded state.
module dino_motion_ctrl #(
  parameter int W         = 11,
  parameter int VW        = 8,
  parameter int V_INIT    = -20,
  parameter int G         = 1,
  parameter int V_CUT     = -6,
  parameter int FAST_FALL = 2,
  parameter int V_MAX     = 20,
  parameter int X_HOME    = 50,
  parameter int ANIM_DIV  = 6,
  parameter int STAND_W   = 44,
  parameter int STAND_H   = 47,
  parameter int DUCK_W    = 59,
  parameter int DUCK_H    = 30
) (
  input  logic                 FrameClk,
  input  logic                 rst,
  input  logic                 jump,
  input  logic                 duck,
  input  logic                 hit,
  input  logic                 restart,
  input  logic [W-1:0]         GroundY,
  output logic [W-1:0]         Dino_X,
  output logic [W-1:0]         Dino_Y,
  output logic signed [VW-1:0] Velocity,
  output logic [2:0]           state,
  output logic [3:0]           dinoSEL,
  output logic [9:0]           DinoWidth,
  output logic [9:0]           DinoHeight,
  output logic                 Airborne,
  output logic                 isDead
);

  localparam int AW = ((W > VW) ? W : VW) + 2;
  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic signed [AW-1:0] ZERO_A = '0;
  localparam logic signed [AW-1:0] VCUT_A = AW'(V_CUT);
  localparam logic signed [AW-1:0] VMAX_A = AW'(V_MAX);

  typedef enum logic [2:0] {RUN = 3'd0, DUCK = 3'd1, RISE = 3'd2, FALL = 3'd3, DEAD = 3'd4} stateT;

  stateT                 curState, nextState;
  logic [W-1:0]          hQ, hNext;
  logic signed [VW-1:0]  vQ, vNext;
  logic [CW-1:0]         animCnt, cntNext;
  logic                  phase, phaseNext;

  logic signed [AW-1:0]  hExt, vExt, gyExt, gEff, vEff, hCalc, vCalc;

  assign hExt  = $signed({{(AW-W){1'b0}}, hQ});
  assign vExt  = {{(AW-VW){vQ[VW-1]}}, vQ};
  assign gyExt = $signed({{(AW-W){1'b0}}, GroundY});
  assign gEff  = AW'(G) + (duck ? AW'(FAST_FALL) : ZERO_A);

  always_ff @(posedge FrameClk or posedge rst) begin
    if (rst) begin
      curState <= RUN;
      hQ       <= '0;
      vQ       <= '0;
      animCnt  <= '0;
      phase    <= 1'b0;
    end else begin
      curState <= nextState;
      hQ       <= hNext;
      vQ       <= vNext;
      animCnt  <= cntNext;
      phase    <= phaseNext;
    end
  end

  always_comb begin
    nextState = curState;
    hNext     = hQ;
    vNext     = vQ;
    cntNext   = animCnt;
    phaseNext = phase;
    vEff      = vExt;
    hCalc     = ZERO_A;
    vCalc     = ZERO_A;
    if (curState == DEAD) begin
      if (restart) begin
        nextState = RUN;
        hNext     = '0;
        vNext     = '0;
        cntNext   = '0;
        phaseNext = 1'b0;
      end
    end else if (hit) begin
      nextState = DEAD;
    end else begin
      case (curState)
        RUN, DUCK: begin
          if (animCnt == CW'(ANIM_DIV - 1)) begin
            cntNext   = '0;
            phaseNext = ~phase;
          end else begin
            cntNext = animCnt + 1'b1;
          end
          if (jump) begin
            nextState = RISE;
            vNext     = VW'(V_INIT);
          end else if (duck) begin
            nextState = DUCK;
          end else begin
            nextState = RUN;
          end
        end
        RISE, FALL: begin
          // Releasing jump early caps upward speed, giving short hops.
          vEff  = (curState == RISE && !jump && vExt < VCUT_A) ? VCUT_A : vExt;
          hCalc = hExt - vEff;
          vCalc = vEff + gEff;
          if (hCalc <= ZERO_A) begin
            hNext     = '0;
            vNext     = '0;
            nextState = duck ? DUCK : RUN;
          end else begin
            hNext = (hCalc > gyExt) ? GroundY : hCalc[W-1:0];
            vNext = (vCalc > VMAX_A) ? VW'(V_MAX) : vCalc[VW-1:0];
            if (curState == RISE && vCalc >= ZERO_A) nextState = FALL;
          end
        end
        default: nextState = RUN;
      endcase
    end
  end

  always_comb begin
    dinoSEL = 4'd0;
    case (curState)
      RUN:     dinoSEL = phase ? 4'd2 : 4'd1;
      DUCK:    dinoSEL = phase ? 4'd4 : 4'd3;
      DEAD:    dinoSEL = 4'd5;
      default: dinoSEL = 4'd0;
    endcase
  end

  assign Dino_X     = W'(X_HOME);
  assign Dino_Y     = GroundY - hQ;
  assign Velocity   = vQ;
  assign state      = curState;
  assign DinoWidth  = (curState == DUCK) ? 10'(DUCK_W) : 10'(STAND_W);
  assign DinoHeight = (curState == DUCK) ? 10'(DUCK_H) : 10'(STAND_H);
  assign Airborne   = (curState == RISE) || (curState == FALL);
  assign isDead     = (curState == DEAD);

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Bench for dino_motion_ctrl: fixed vector table, directed jump/duck/death/reset sequences, random run vs reference model.
module tb_dino_motion_ctrl;

  logic              FrameClk = 1'b0;
  logic              rst, jump, duck, hit, restart;
  logic [10:0]       GroundY;
  logic [10:0]       Dino_X, Dino_Y;
  logic signed [7:0] Velocity;
  logic [2:0]        state;
  logic [3:0]        dinoSEL;
  logic [9:0]        DinoWidth, DinoHeight;
  logic              Airborne, isDead;

  dino_motion_ctrl dut (
    .FrameClk(FrameClk), .rst(rst), .jump(jump), .duck(duck), .hit(hit),
    .restart(restart), .GroundY(GroundY), .Dino_X(Dino_X), .Dino_Y(Dino_Y),
    .Velocity(Velocity), .state(state), .dinoSEL(dinoSEL), .DinoWidth(DinoWidth),
    .DinoHeight(DinoHeight), .Airborne(Airborne), .isDead(isDead)
  );

  always #5 FrameClk = ~FrameClk;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: 0 RUN, 1 DUCK, 2 RISE, 3 FALL, 4 DEAD
  int mState, mH, mV, mCnt, mPhase;

  task automatic chk(string name, int act, int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void mReset();
    mState = 0; mH = 0; mV = 0; mCnt = 0; mPhase = 0;
  endfunction

  function automatic void mStep(bit j, bit d, bit h, bit r, int gy);
    int ve, nh, nv;
    if (mState == 4) begin
      if (r) mReset();
      return;
    end
    if (h) begin
      mState = 4;
      return;
    end
    if (mState <= 1) begin
      mCnt = mCnt + 1;
      if (mCnt == 6) begin mCnt = 0; mPhase = 1 - mPhase; end
      if (j) begin mState = 2; mV = -20; end
      else mState = d ? 1 : 0;
    end else begin
      ve = (mState == 2 && !j && mV < -6) ? -6 : mV;
      nh = mH - ve;
      if (nh <= 0) begin
        mH = 0; mV = 0; mState = d ? 1 : 0;
      end else begin
        mH = (nh > gy) ? gy : nh;
        nv = ve + 1 + (d ? 2 : 0);
        mV = (nv > 20) ? 20 : nv;
        if (mState == 2 && mV >= 0) mState = 3;
      end
    end
  endfunction

  task automatic cmpModel(string tag);
    int ey, esel;
    ey = (int'(GroundY) - mH) & 32'h7FF;
    case (mState)
      0: esel = mPhase ? 2 : 1;
      1: esel = mPhase ? 4 : 3;
      4: esel = 5;
      default: esel = 0;
    endcase
    chk({tag, ".state"}, int'(state), mState);
    chk({tag, ".Dino_Y"}, int'(Dino_Y), ey);
    chk({tag, ".Velocity"}, int'(Velocity), mV);
    chk({tag, ".dinoSEL"}, int'(dinoSEL), esel);
    chk({tag, ".DinoWidth"}, int'(DinoWidth), (mState == 1) ? 59 : 44);
    chk({tag, ".DinoHeight"}, int'(DinoHeight), (mState == 1) ? 30 : 47);
    chk({tag, ".Airborne"}, int'(Airborne), (mState == 2 || mState == 3) ? 1 : 0);
    chk({tag, ".isDead"}, int'(isDead), (mState == 4) ? 1 : 0);
    chk({tag, ".Dino_X"}, int'(Dino_X), 50);
  endtask

  // Drive inputs, advance model and DUT one frame, compare just after the edge.
  task automatic step(string tag, bit j, bit d, bit h, bit r);
    jump = j; duck = d; hit = h; restart = r;
    mStep(j, d, h, r, int'(GroundY));
    @(posedge FrameClk);
    #1;
    cmpModel(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic doReset(int gy);
    GroundY = 11'(gy);
    jump = 0; duck = 0; hit = 0; restart = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mReset();
  endtask

  task automatic chkResetValues(string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".Dino_X"}, int'(Dino_X), 50);
    chk({tag, ".Dino_Y"}, int'(Dino_Y), int'(GroundY));
    chk({tag, ".Velocity"}, int'(Velocity), 0);
    chk({tag, ".dinoSEL"}, int'(dinoSEL), 1);
    chk({tag, ".Airborne"}, int'(Airborne), 0);
    chk({tag, ".isDead"}, int'(isDead), 0);
    chk({tag, ".DinoWidth"}, int'(DinoWidth), 44);
    chk({tag, ".DinoHeight"}, int'(DinoHeight), 47);
  endtask

  typedef struct {
    bit j, d, h, r;
    int st, y, v;
  } vecT;

  vecT tbl[10];
  int  selAt[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Row-by-row expectations, starting from reset on GroundY=300.
    tbl[0] = '{0, 0, 0, 0, 0, 300, 0};
    tbl[1] = '{0, 1, 0, 0, 1, 300, 0};
    tbl[2] = '{1, 1, 0, 0, 2, 300, -20};
    tbl[3] = '{1, 0, 0, 0, 2, 280, -19};
    tbl[4] = '{1, 0, 1, 0, 4, 280, -19};
    tbl[5] = '{0, 0, 0, 0, 4, 280, -19};
    tbl[6] = '{0, 0, 1, 1, 0, 300, 0};
    tbl[7] = '{0, 0, 1, 1, 4, 300, 0};
    tbl[8] = '{0, 0, 0, 1, 0, 300, 0};
    tbl[9] = '{0, 1, 0, 0, 1, 300, 0};

    rst = 1'b1; jump = 0; duck = 0; hit = 0; restart = 0; GroundY = 11'd300;
    #12;
    chkResetValues("reset");
    rst = 1'b0;
    mReset();

    for (int i = 0; i < 10; i++) begin
      step("tbl", tbl[i].j, tbl[i].d, tbl[i].h, tbl[i].r);
      chk($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d.Dino_Y", i), int'(Dino_Y), tbl[i].y);
      chk($sformatf("tbl%0d.Velocity", i), int'(Velocity), tbl[i].v);
    end

    // Held jump: apex after 20 updates, landing 41 frames after launch.
    doReset(300);
    step("held", 1, 0, 0, 0);
    for (int n = 1; n <= 20; n++) step("held", 1, 0, 0, 0);
    chk("held.apexY", int'(Dino_Y), 90);
    chk("held.apexState", int'(state), 3);
    for (int n = 21; n <= 41; n++) step("held", 1, 0, 0, 0);
    chk("held.landState", int'(state), 0);
    chk("held.landY", int'(Dino_Y), 300);

    // One-frame tap: short hop peaks at 21.
    doReset(300);
    step("tap", 1, 0, 0, 0);
    for (int n = 1; n <= 6; n++) step("tap", 0, 0, 0, 0);
    chk("tap.peakY", int'(Dino_Y), 279);
    chk("tap.peakV", int'(Velocity), 0);
    chk("tap.state", int'(state), 3);

    // Duck held from the ground: leg phase flips every 6 frames.
    doReset(300);
    for (int n = 1; n <= 13; n++) begin
      step("duck", 0, 1, 0, 0);
      selAt[n] = int'(dinoSEL);
    end
    chk("duck.state", int'(state), 1);
    chk("duck.width", int'(DinoWidth), 59);
    chk("duck.height", int'(DinoHeight), 30);
    chk("duck.sel5", selAt[5], 3);
    chk("duck.sel6", selAt[6], 4);
    chk("duck.sel11", selAt[11], 4);
    chk("duck.sel12", selAt[12], 3);
    step("duckjump", 1, 1, 0, 0);
    chk("duckjump.state", int'(state), 2);
    chk("duckjump.width", int'(DinoWidth), 44);

    // Hit mid-rise at H=105 freezes height/velocity until restart.
    doReset(300);
    step("hit", 1, 0, 0, 0);
    for (int n = 1; n <= 6; n++) step("hit", 1, 0, 0, 0);
    chk("hit.preY", int'(Dino_Y), 195);
    step("hit", 1, 0, 1, 0);
    chk("hit.state", int'(state), 4);
    chk("hit.sel", int'(dinoSEL), 5);
    for (int n = 0; n < 10; n++) step("dead", n[0], n[1], n[2], 0);
    chk("dead.frozenY", int'(Dino_Y), 195);
    chk("dead.frozenV", int'(Velocity), -14);
    step("restart", 0, 0, 0, 1);
    chk("restart.state", int'(state), 0);
    chk("restart.Y", int'(Dino_Y), 300);
    step("hitrestart", 0, 0, 1, 1);
    chk("hitrestart.state", int'(state), 4);

    // Ceiling: height saturates at GroundY while velocity keeps integrating.
    doReset(200);
    step("ceil", 1, 0, 0, 0);
    for (int n = 1; n <= 17; n++) step("ceil", 1, 0, 0, 0);
    chk("ceil.Y", int'(Dino_Y), 0);
    chk("ceil.V", int'(Velocity), -3);
    for (int n = 18; n <= 30; n++) step("ceil", 1, 0, 0, 0);

    // Reset asserted mid-fall, between clock edges.
    doReset(300);
    step("fall", 1, 0, 0, 0);
    for (int n = 1; n <= 25; n++) step("fall", 1, 0, 0, 0);
    chk("fall.state", int'(state), 3);
    #3;
    rst = 1'b1;
    #1;
    chkResetValues("asyncrst");
    rst = 1'b0;
    mReset();

    // Randomized play against the reference model.
    for (int seg = 0; seg < 15; seg++) begin
      doReset(int'($urandom_range(60, 1500)));
      for (int n = 0; n < 200; n++)
        step("rand", $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
